multi_barrel_shifter_reverser: RTL and testbench

//   Multi-function rotator for a 2**N-bit word: rotates right (s=0) or left (s=1)
//   by AMT positions.

---
 rtl/mbsr_pkg.sv | 26 ++
 rtl/rotr_core.sv | 29 ++
 rtl/multi_barrel_shifter_reverser.sv | 91 +++++++++
 tb/tb_multi_barrel_shifter_reverser.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mbsr_pkg.sv
// Shared types and helpers for the multi-function rotator.
// Configuration macro: MBSR_INPUT_REG_EN (registers A/AMT/s ahead of the rotate core).
package mbsr_pkg;

    localparam int MBSR_N     = 3;
    localparam int MBSR_MAX_W = 64;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

    // Reverses the low w bits of d; bits above w come back as zero.
    function automatic logic [MBSR_MAX_W-1:0] bit_reverse(
        input logic [MBSR_MAX_W-1:0] d,
        input int                    w
    );
        logic [MBSR_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MBSR_MAX_W; i++) begin
            r[i] = d[MBSR_MAX_W-1-i];
        end
        return r >> (MBSR_MAX_W - w);
    endfunction

endpackage

// File: rtl/rotr_core.sv
// Purely combinational log-stage right rotator: stage k rotates right by 2**k
// when amt[k] is set, so N stages cover every amount 0..W-1.
module rotr_core #(
    parameter int N = 3
) (
    input  logic [2**N-1:0] d,
    input  logic [N-1:0]    amt,
    output logic [2**N-1:0] q
);

    localparam int W = 2**N;

    for (genvar k = 0; k < N; k++) begin : g_stage
        localparam int SH = 2**k;
        logic [W-1:0] din;
        logic [W-1:0] dout;

        if (k == 0) begin : g_first
            assign din = d;
        end else begin : g_chain
            assign din = g_stage[k-1].dout;
        end

        assign dout = amt[k] ? {din[SH-1:0], din[W-1:SH]} : din;
    end

    assign q = g_stage[N-1].dout;

endmodule

// File: rtl/multi_barrel_shifter_reverser.sv
// Rotates a 2**N-bit word right (s=0) or left (s=1); left rotation is done as
// rev(rotr(rev(A), AMT)) around a single right-rotation core. Output is registered.
// Defining MBSR_INPUT_REG_EN adds an input register stage (latency 1 -> 2 clk).
module multi_barrel_shifter_reverser
    import mbsr_pkg::*;
#(
    parameter int N = MBSR_N
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2**N-1:0] A,
    input  logic [N-1:0]    AMT,
    input  logic            s,
    output logic [2**N-1:0] Y
);

    localparam int W = 2**N;

    // No handshake: a new A/AMT/s triple is taken on every rising edge and
    // its result appears a fixed number of edges later; reset drops everything in flight.
    logic [W-1:0] core_a;
    logic [N-1:0] core_amt;
    dir_e         core_dir;

`ifdef MBSR_INPUT_REG_EN
    logic [W-1:0] a_d,   a_q;
    logic [N-1:0] amt_d, amt_q;
    dir_e         dir_d, dir_q;

    always_comb begin
        a_d   = A;
        amt_d = AMT;
        dir_d = dir_e'(s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= '0;
            amt_q <= '0;
            dir_q <= DIR_RIGHT;
        end else begin
            a_q   <= a_d;
            amt_q <= amt_d;
            dir_q <= dir_d;
        end
    end

    assign core_a   = a_q;
    assign core_amt = amt_q;
    assign core_dir = dir_q;
`else
    assign core_a   = A;
    assign core_amt = AMT;
    assign core_dir = dir_e'(s);
`endif

    logic [MBSR_MAX_W-1:0] rev_in_full;
    logic [MBSR_MAX_W-1:0] rev_out_full;
    logic [W-1:0]          rot_in;
    logic [W-1:0]          rot_out;
    logic [W-1:0]          y_d, y_q;

    always_comb begin
        rev_in_full = bit_reverse(MBSR_MAX_W'(core_a), W);
        rot_in      = (core_dir == DIR_LEFT) ? rev_in_full[W-1:0] : core_a;
    end

    rotr_core #(
        .N (N)
    ) u_rotr_core (
        .d   (rot_in),
        .amt (core_amt),
        .q   (rot_out)
    );

    always_comb begin
        rev_out_full = bit_reverse(MBSR_MAX_W'(rot_out), W);
        y_d          = (core_dir == DIR_LEFT) ? rev_out_full[W-1:0] : rot_out;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            y_q <= '0;
        end else begin
            y_q <= y_d;
        end
    end

    assign Y = y_q;

endmodule

// File: tb/tb_multi_barrel_shifter_reverser.sv
// Directed and exhaustive-sweep bench for multi_barrel_shifter_reverser (N=3, W=8).
// Inputs change on the falling edge; Y is compared on the falling edge L edges later.
module tb_multi_barrel_shifter_reverser;

    localparam int N = 3;
    localparam int W = 8;
`ifdef MBSR_INPUT_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A;
    logic [N-1:0] AMT;
    logic         s;
    logic [W-1:0] Y;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    string        tag_q[$];

    multi_barrel_shifter_reverser #(
        .N (N)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .AMT   (AMT),
        .s     (s),
        .Y     (Y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Index-formula reference: right Y[i]=A[(i+amt)%W], left Y[i]=A[(i-amt)%W].
    function automatic logic [W-1:0] ref_rot(input logic [W-1:0] a, input int amt, input logic left);
        logic [W-1:0] y;
        for (int i = 0; i < W; i++) begin
            if (left) y[i] = a[(i - amt + W) % W];
            else      y[i] = a[(i + amt) % W];
        end
        return y;
    endfunction

    // Entered and left on a falling edge: checks the oldest due result, then drives new inputs.
    task automatic step(input string tag, input logic [W-1:0] a, input int amt, input logic sv,
                        input logic [W-1:0] exp);
        if (exp_q.size() == L) begin
            check(tag_q.pop_front(), Y, exp_q.pop_front());
        end
        A   = a;
        AMT = N'(amt);
        s   = sv;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
    endtask

    // Reset with A changing in the same cycle; everything in flight is dropped.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        A     = 8'hFF;
        AMT   = 3'd5;
        s     = 1'b1;
        exp_q.delete();
        tag_q.delete();
        repeat (cycles) begin
            @(negedge clk);
            check("reset_y_zero", Y, 8'h00);
        end
        reset = 1'b0;
        // With an input stage, its cleared contents produce one zero result first.
        for (int i = 0; i < L - 1; i++) begin
            exp_q.push_back(8'h00);
            tag_q.push_back("post_reset");
        end
    endtask

    task automatic flush();
        logic [W-1:0] a_hold;
        logic [N-1:0] amt_hold;
        logic         s_hold;
        a_hold   = A;
        amt_hold = AMT;
        s_hold   = s;
        repeat (L) step("flush", a_hold, int'(amt_hold), s_hold, ref_rot(a_hold, int'(amt_hold), s_hold));
    endtask

    initial begin
        logic [W-1:0] a;
        int           amt;
        logic         sv;

        reset = 1'b1;
        A     = '0;
        AMT   = '0;
        s     = 1'b0;
        @(negedge clk);
        do_reset(2);

        step("f0_amt0_r", 8'hF0, 0, 1'b0, 8'hF0);
        step("f0_amt0_l", 8'hF0, 0, 1'b1, 8'hF0);
        step("f0_amt1_r", 8'hF0, 1, 1'b0, 8'h78);
        step("f0_amt1_l", 8'hF0, 1, 1'b1, 8'hE1);
        step("f0_amt4_r", 8'hF0, 4, 1'b0, 8'h0F);
        step("f0_amt4_l", 8'hF0, 4, 1'b1, 8'h0F);
        step("81_amt7_r", 8'h81, 7, 1'b0, 8'h03);
        step("81_amt7_l", 8'h81, 7, 1'b1, 8'hC0);
        step("01_amt3_l", 8'h01, 3, 1'b1, 8'h08);
        step("01_amt3_r", 8'h01, 3, 1'b0, 8'h20);
        flush();

        // Every amount, both directions, every single-bit position, back to back.
        for (int am = 0; am < W; am++) begin
            for (int d = 0; d < 2; d++) begin
                for (int b = 0; b < W; b++) begin
                    a = '0;
                    a[b] = 1'b1;
                    step("sweep_onehot", a, am, d[0], ref_rot(a, am, d[0]));
                end
            end
        end

        for (int i = 0; i < 100; i++) begin
            a   = W'($urandom_range(0, 255));
            amt = $urandom_range(0, W - 1);
            sv  = 1'($urandom_range(0, 1));
            step("random", a, amt, sv, ref_rot(a, amt, sv));
        end

        do_reset(1);

        for (int i = 0; i < 40; i++) begin
            a   = W'($urandom_range(0, 255));
            amt = $urandom_range(0, W - 1);
            sv  = 1'($urandom_range(0, 1));
            step("after_reset", a, amt, sv, ref_rot(a, amt, sv));
        end
        flush();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
